// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock; WIDTH steps per operation.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             dvz;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a_raw;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     acc_step;
  logic [WIDTH-1:0]   q_step;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  assign busy = (state != IDLE);

  // acc/q are shared: multiply keeps {upper partial, multiplier}; divide keeps {remainder, dividend/quotient}
  always_comb begin
    mult_sum  = acc;
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d};
    acc_step  = acc;
    q_step    = q;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_step = div_diff;
        q_step   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_shift;
        q_step   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      mult_sum = acc + (q[0] ? {1'b0, d} : '0);
      acc_step = {1'b0, mult_sum[WIDTH:1]};
      q_step   = {mult_sum[0], q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {acc[WIDTH-1:0], q};
    prod_fix = neg_lo ? -prod : prod;
    q_fix    = neg_lo ? -q : q;
    r_fix    = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dvz         <= 1'b0;
      acc         <= '0;
      q           <= '0;
      d           <= '0;
      a_raw       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dvz    <= op[1] && (B == '0);
            a_raw  <= A;
            acc    <= '0;
            cnt    <= '0;
            if (op[1]) begin
              q <= a_mag;
              d <= b_mag;
            end else begin
              q <= b_mag;
              d <= a_mag;
            end
          end else begin
            if (hi_we) hi <= A;
            if (lo_we) lo <= A;
          end
        end
        RUN: begin
          acc <= acc_step;
          q   <= q_step;
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          done        <= 1'b1;
          div_by_zero <= dvz;
          if (dvz) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic        start;
  logic [1:0]  op;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .start       (start),
    .op          (op),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a; rl = 32'hFFFF_FFFF; rz = 1'b1;
        end else if (o == 2'b10) begin
          sp = sa / sb; rl = sp[31:0];
          sp = sa % sb; rh = sp[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rh, input logic [31:0] rl, input logic rz,
                        input bit disturb, input bit with_lo_we);
    int early_done = 0;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1; lo_we = with_lo_we; hi_we = 1'b0;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1);
    start = 1'b0; lo_we = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (done) early_done++;
      if (disturb && i == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; A = $urandom;
      end
      if (disturb && i == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    check("busy_before_fin", busy, 1);
    check("no_early_done", early_done, 0);
    check("hi_held_run", hi, exp_hi);
    check("lo_held_run", lo, exp_lo);
    @(posedge clk); #1;
    exp_hi = rh; exp_lo = rl; exp_dz = rz;
    check("done_pulse", done, 1);
    check("busy_low_at_fin", busy, 0);
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
    check("div_by_zero", div_by_zero, exp_dz);
    @(posedge clk); #1;
    check("done_cleared", done, 0);
    check("no_queued_start", busy, 0);
    check("dz_held", div_by_zero, exp_dz);
  endtask

  task automatic run_rand(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] rh, rl;
    logic rz;
    model(o, a, b, rh, rl, rz);
    run_op(o, a, b, rh, rl, rz, 1'b0, 1'b0);
  endtask

  initial begin
    int dones;
    logic [31:0] ra, rb, rh, rl;
    logic rz;
    rst = 1'b1; A = '0; B = '0; start = 1'b0; op = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    // directed cases with hand-derived results
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    // second start plus moves while busy must be ignored
    run_op(2'b00, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FC18, 1'b0, 1'b1, 1'b0);

    // moves in IDLE
    @(negedge clk); A = 32'h1234_5678; hi_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0;
    exp_hi = 32'h1234_5678;
    check("mthi_hi", hi, exp_hi);
    check("mthi_lo_kept", lo, exp_lo);
    @(negedge clk); A = 32'hCAFE_F00D; lo_we = 1'b1;
    @(posedge clk); #1; lo_we = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    check("mtlo_lo", lo, exp_lo);
    check("mtlo_hi_kept", hi, exp_hi);
    @(negedge clk); A = 32'h0BAD_BEEF; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'h0BAD_BEEF; exp_lo = 32'h0BAD_BEEF;
    check("mt_both_hi", hi, exp_hi);
    check("mt_both_lo", lo, exp_lo);

    // start wins over lo_we in the same cycle
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        2: ra = -32'($urandom_range(1, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_rand(2'($urandom_range(0, 3)), ra, rb);
    end

    // reset in the middle of RUN abandons the operation
    model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rz);
    @(negedge clk); op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    check("midrun_rst_hi", hi, exp_hi);
    check("midrun_rst_lo", lo, exp_lo);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrun_no_done", dones, 0);
    check("midrun_hi_after", hi, exp_hi);
    check("midrun_lo_after", lo, exp_lo);
    check("midrun_busy_after", busy, 0);

    // unit still works after the abandoned operation
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rz, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
